// File: rtl/seg_pkg.sv
// Shared 7-segment constants and the team character table.
package seg_pkg;

    localparam int unsigned SEG_W      = 8;
    localparam int unsigned SEG_DP_BIT = 7;
    localparam int unsigned SEG_G_BIT  = 6;
    localparam int unsigned SEG_A_BIT  = 0;
    localparam int unsigned CODE_W     = 5;
    localparam int unsigned BLANK_CODE = 31;
    localparam logic [6:0]  SEG7_OFF   = 7'h7F;

    // Active-low g..a pattern: 0-9 digits, 10-30 letters, 31 blank.
    function automatic logic [6:0] char_to_seg7(input logic [CODE_W-1:0] code);
        logic [6:0] s;
        case (code)
            5'd0:    s = 7'h40;
            5'd1:    s = 7'h79;
            5'd2:    s = 7'h24;
            5'd3:    s = 7'h30;
            5'd4:    s = 7'h19;
            5'd5:    s = 7'h12;
            5'd6:    s = 7'h02;
            5'd7:    s = 7'h78;
            5'd8:    s = 7'h00;
            5'd9:    s = 7'h10;
            5'd10:   s = 7'h08; // A
            5'd11:   s = 7'h03; // b
            5'd12:   s = 7'h46; // C
            5'd13:   s = 7'h21; // d
            5'd14:   s = 7'h06; // E
            5'd15:   s = 7'h0E; // F
            5'd16:   s = 7'h42; // G
            5'd17:   s = 7'h09; // H
            5'd18:   s = 7'h79; // I
            5'd19:   s = 7'h61; // J
            5'd20:   s = 7'h47; // L
            5'd21:   s = 7'h2B; // n
            5'd22:   s = 7'h23; // o
            5'd23:   s = 7'h0C; // P
            5'd24:   s = 7'h18; // q
            5'd25:   s = 7'h2F; // r
            5'd26:   s = 7'h12; // S
            5'd27:   s = 7'h07; // t
            5'd28:   s = 7'h41; // U
            5'd29:   s = 7'h11; // y
            5'd30:   s = 7'h24; // Z
            default: s = SEG7_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_page_scanner_if.sv
// Control/data inputs and display outputs of the page scanner.
interface seg_page_scanner_if #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned NUM_PAGES  = 2,
    parameter int unsigned CHAR_W     = 5
);
    import seg_pkg::*;

    localparam int unsigned PAGE_W = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;

    logic                             mode;
    logic                             step;
    logic                             blank_all;
    logic [NUM_PAGES-1:0]             page_valid;
    logic [NUM_PAGES*NUM_DIGITS*CHAR_W-1:0] page_chars;
    logic [NUM_PAGES*NUM_DIGITS-1:0]  page_dp;
    logic [NUM_DIGITS-1:0]            anode;
    logic [SEG_W-1:0]                 seg;
    logic [PAGE_W-1:0]                page_idx;
    logic                             page_tick;

    modport master (
        output mode, step, blank_all, page_valid, page_chars, page_dp,
        input  anode, seg, page_idx, page_tick
    );

    modport slave (
        input  mode, step, blank_all, page_valid, page_chars, page_dp,
        output anode, seg, page_idx, page_tick
    );

endinterface

// File: rtl/seg_char_decode.sv
// Character code plus decimal point to active-low 8-bit segment pattern.
module seg_char_decode
    import seg_pkg::*;
#(
    parameter int unsigned CHAR_W = 5
) (
    input  logic [CHAR_W-1:0] code,
    input  logic              dp,
    output logic [SEG_W-1:0]  seg_c
);

    logic in_table;

    // Codes above the table (only possible when CHAR_W > 5) render blank.
    always_comb begin
        in_table = (32'(code) <= BLANK_CODE);
        seg_c    = '1;
        seg_c[SEG_DP_BIT] = ~dp;
        seg_c[SEG_G_BIT:SEG_A_BIT] = in_table ? char_to_seg7(CODE_W'(code)) : SEG7_OFF;
    end

endmodule

// File: rtl/seg_page_scanner.sv
// Multi-page multiplexed 7-segment driver with auto/manual page rotation.
module seg_page_scanner
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned NUM_PAGES   = 2,
    parameter int unsigned CHAR_W      = 5,
    parameter int unsigned REFRESH_DIV = 100_000,
    parameter int unsigned DWELL_DIV   = 200_000_000
) (
    input  logic               clk,
    input  logic               reset,
    seg_page_scanner_if.slave  bus
);

    localparam int unsigned PAGE_W = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
    localparam int unsigned DIG_W  = $clog2(NUM_DIGITS);
    localparam int unsigned REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned DWL_W  = (DWELL_DIV > 1) ? $clog2(DWELL_DIV) : 1;

    logic [REF_W-1:0]      refresh_cnt_q, refresh_cnt_d;
    logic [DIG_W-1:0]      digit_idx_q, digit_idx_d;
    logic [DWL_W-1:0]      dwell_cnt_q, dwell_cnt_d;
    logic [PAGE_W-1:0]     page_idx_q, page_idx_d;
    logic                  page_tick_q, page_tick_d;
    logic                  mode_q, mode_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [SEG_W-1:0]      seg_q, seg_d;

    logic                  refresh_wrap, dwell_wrap, cur_valid, page_change, dark;
    logic                  nxt_found;
    logic [PAGE_W-1:0]     nxt_page, cand;
    logic [CHAR_W-1:0]     char_code;
    logic                  char_dp;
    logic [SEG_W-1:0]      seg_c;

    // First valid page after the current one, wrapping; excludes the current page.
    always_comb begin
        nxt_found = 1'b0;
        nxt_page  = page_idx_q;
        cand      = page_idx_q;
        for (int unsigned k = 1; k < NUM_PAGES; k++) begin
            cand = PAGE_W'((32'(page_idx_q) + k) % NUM_PAGES);
            if (!nxt_found && bus.page_valid[cand]) begin
                nxt_found = 1'b1;
                nxt_page  = cand;
            end
        end
    end

    // Digit mux selects from the registered page/digit so outputs never mix them.
    always_comb begin
        char_code = '0;
        char_dp   = 1'b0;
        for (int unsigned i = 0; i < NUM_PAGES * NUM_DIGITS; i++) begin
            if (i == 32'(page_idx_q) * NUM_DIGITS + 32'(digit_idx_q)) begin
                char_code = bus.page_chars[i*CHAR_W +: CHAR_W];
                char_dp   = bus.page_dp[i];
            end
        end
    end

    seg_char_decode #(.CHAR_W(CHAR_W)) u_decode (
        .code  (char_code),
        .dp    (char_dp),
        .seg_c (seg_c)
    );

    always_comb begin
        refresh_cnt_d = refresh_cnt_q + REF_W'(1);
        digit_idx_d   = digit_idx_q;
        dwell_cnt_d   = dwell_cnt_q + DWL_W'(1);
        page_idx_d    = page_idx_q;
        page_tick_d   = 1'b0;
        mode_d        = bus.mode;
        anode_d       = '1;
        seg_d         = '1;

        refresh_wrap = (refresh_cnt_q == REF_W'(REFRESH_DIV - 1));
        if (refresh_wrap) begin
            refresh_cnt_d = '0;
            digit_idx_d   = (digit_idx_q == DIG_W'(NUM_DIGITS - 1)) ? '0
                                                                    : digit_idx_q + DIG_W'(1);
        end

        // Invalid current page, dwell wrap and step all collapse into one advance.
        dwell_wrap  = !bus.mode && (dwell_cnt_q == DWL_W'(DWELL_DIV - 1));
        cur_valid   = bus.page_valid[page_idx_q];
        page_change = nxt_found && (!cur_valid || dwell_wrap || bus.step);
        if (page_change) begin
            page_idx_d  = nxt_page;
            page_tick_d = 1'b1;
        end

        if (page_change || dwell_wrap || bus.mode || (bus.mode != mode_q)) begin
            dwell_cnt_d = '0;
        end

        dark = bus.blank_all || (bus.page_valid == '0);
        if (!dark) begin
            anode_d = ~(NUM_DIGITS'(1) << digit_idx_q);
            seg_d   = seg_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt_q <= '0;
            digit_idx_q   <= '0;
            dwell_cnt_q   <= '0;
            page_idx_q    <= '0;
            page_tick_q   <= 1'b0;
            mode_q        <= 1'b0;
            anode_q       <= '1;
            seg_q         <= '1;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            digit_idx_q   <= digit_idx_d;
            dwell_cnt_q   <= dwell_cnt_d;
            page_idx_q    <= page_idx_d;
            page_tick_q   <= page_tick_d;
            mode_q        <= mode_d;
            anode_q       <= anode_d;
            seg_q         <= seg_d;
        end
    end

    assign bus.anode     = anode_q;
    assign bus.seg       = seg_q;
    assign bus.page_idx  = page_idx_q;
    assign bus.page_tick = page_tick_q;

endmodule

// File: tb/tb_seg_page_scanner.sv
// Directed bench for seg_page_scanner: 4 digits, 3 pages, short refresh and dwell.
module tb_seg_page_scanner;

    localparam int unsigned ND = 4;
    localparam int unsigned NP = 3;
    localparam int unsigned CW = 5;
    localparam int unsigned RD = 4;
    localparam int unsigned DD = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [4:0] chars [NP][ND];

    always #5 clk = ~clk;

    seg_page_scanner_if #(.NUM_DIGITS(ND), .NUM_PAGES(NP), .CHAR_W(CW)) bus ();

    seg_page_scanner #(
        .NUM_DIGITS(ND), .NUM_PAGES(NP), .CHAR_W(CW),
        .REFRESH_DIV(RD), .DWELL_DIV(DD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Hand-written active-low patterns, dp off.
    function automatic logic [7:0] exp_seg(input logic [4:0] code);
        case (code)
            5'd0:  return 8'hC0;
            5'd1:  return 8'hF9;
            5'd2:  return 8'hA4;
            5'd3:  return 8'hB0;
            5'd4:  return 8'h99;
            5'd5:  return 8'h92;
            5'd6:  return 8'h82;
            5'd7:  return 8'hF8;
            5'd8:  return 8'h80;
            5'd9:  return 8'h90;
            5'd10: return 8'h88;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_chars();
        chars[0][0] = 5'd1; chars[0][1] = 5'd2; chars[0][2] = 5'd3; chars[0][3] = 5'd4;
        chars[1][0] = 5'd5; chars[1][1] = 5'd6; chars[1][2] = 5'd7; chars[1][3] = 5'd8;
        chars[2][0] = 5'd9; chars[2][1] = 5'd0; chars[2][2] = 5'd1; chars[2][3] = 5'd2;
    endtask

    task automatic load_chars();
        for (int p = 0; p < int'(NP); p++)
            for (int d = 0; d < int'(ND); d++)
                bus.page_chars[(p*int'(ND)+d)*int'(CW) +: CW] = chars[p][d];
    endtask

    task automatic do_reset();
        bus.mode = 1'b0; bus.step = 1'b0; bus.blank_all = 1'b0;
        bus.page_valid = 3'b111; bus.page_dp = '0;
        init_chars();
        load_chars();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        tick();
        n_tests++; if (bus.anode !== 4'b1111) begin n_fail++; $display("FAIL reset_anode: got %b expected 1111", bus.anode); end
        n_tests++; if (bus.seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h expected ff", bus.seg); end
        n_tests++; if (bus.page_idx !== 2'd0) begin n_fail++; $display("FAIL reset_page: got %0d expected 0", bus.page_idx); end
        n_tests++; if (bus.page_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", bus.page_tick); end
        reset = 1'b0;
    endtask

    task automatic test_auto_rotate();
        int d, p;
        logic [3:0] ea;
        do_reset();
        for (int n = 1; n <= 200; n++) begin
            tick();
            d  = ((n - 1) / int'(RD)) % int'(ND);
            p  = ((n - 1) / int'(DD)) % int'(NP);
            ea = 4'b1111 ^ (4'b0001 << d);
            n_tests++; if (bus.anode !== ea) begin n_fail++; $display("FAIL auto_anode n=%0d: got %b expected %b", n, bus.anode, ea); end
            n_tests++; if (bus.seg !== exp_seg(chars[p][d])) begin n_fail++; $display("FAIL auto_seg n=%0d: got %h expected %h", n, bus.seg, exp_seg(chars[p][d])); end
            n_tests++; if (bus.page_idx !== 2'((n / int'(DD)) % int'(NP))) begin n_fail++; $display("FAIL auto_page n=%0d: got %0d expected %0d", n, bus.page_idx, (n / int'(DD)) % int'(NP)); end
            n_tests++; if (bus.page_tick !== ((n % int'(DD)) == 0)) begin n_fail++; $display("FAIL auto_tick n=%0d: got %b expected %b", n, bus.page_tick, (n % int'(DD)) == 0); end
        end
    endtask

    task automatic test_skip_invalid();
        logic [1:0] ep;
        do_reset();
        bus.page_valid = 3'b101;
        for (int n = 1; n <= 200; n++) begin
            tick();
            ep = (((n / int'(DD)) % 2) == 0) ? 2'd0 : 2'd2;
            n_tests++; if (bus.page_idx !== ep) begin n_fail++; $display("FAIL skip_page n=%0d: got %0d expected %0d", n, bus.page_idx, ep); end
        end
    endtask

    task automatic test_manual_step();
        do_reset();
        bus.mode = 1'b1;
        for (int n = 1; n <= 9; n++) tick();
        n_tests++; if (bus.page_idx !== 2'd0) begin n_fail++; $display("FAIL manual_idle: got %0d expected 0", bus.page_idx); end
        bus.step = 1'b1;
        tick();
        n_tests++; if (bus.page_idx !== 2'd1) begin n_fail++; $display("FAIL manual_step1: got %0d expected 1", bus.page_idx); end
        n_tests++; if (bus.page_tick !== 1'b1) begin n_fail++; $display("FAIL manual_tick1: got %b expected 1", bus.page_tick); end
        tick();
        n_tests++; if (bus.page_idx !== 2'd2) begin n_fail++; $display("FAIL manual_step2: got %0d expected 2", bus.page_idx); end
        bus.step = 1'b0;
        for (int n = 0; n < 200; n++) begin
            tick();
            n_tests++; if (bus.page_idx !== 2'd2 || bus.page_tick !== 1'b0) begin n_fail++; $display("FAIL manual_hold n=%0d: got page %0d tick %b expected page 2 tick 0", n, bus.page_idx, bus.page_tick); end
        end
    endtask

    task automatic test_step_dwell_collision();
        do_reset();
        for (int n = 1; n <= 63; n++) tick();
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        n_tests++; if (bus.page_idx !== 2'd1) begin n_fail++; $display("FAIL coll_page: got %0d expected 1", bus.page_idx); end
        n_tests++; if (bus.page_tick !== 1'b1) begin n_fail++; $display("FAIL coll_tick: got %b expected 1", bus.page_tick); end
        tick();
        n_tests++; if (bus.page_idx !== 2'd1 || bus.page_tick !== 1'b0) begin n_fail++; $display("FAIL coll_after: got page %0d tick %b expected page 1 tick 0", bus.page_idx, bus.page_tick); end
        for (int n = 66; n <= 127; n++) tick();
        n_tests++; if (bus.page_idx !== 2'd1) begin n_fail++; $display("FAIL coll_dwell_hold: got %0d expected 1", bus.page_idx); end
        tick();
        n_tests++; if (bus.page_idx !== 2'd2 || bus.page_tick !== 1'b1) begin n_fail++; $display("FAIL coll_dwell_next: got page %0d tick %b expected page 2 tick 1", bus.page_idx, bus.page_tick); end
    endtask

    task automatic test_invalidate_current();
        do_reset();
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        n_tests++; if (bus.page_idx !== 2'd1 || bus.page_tick !== 1'b1) begin n_fail++; $display("FAIL inval_setup: got page %0d tick %b expected page 1 tick 1", bus.page_idx, bus.page_tick); end
        for (int n = 2; n <= 5; n++) tick();
        bus.page_valid = 3'b101;
        tick();
        n_tests++; if (bus.page_idx !== 2'd2 || bus.page_tick !== 1'b1) begin n_fail++; $display("FAIL inval_move: got page %0d tick %b expected page 2 tick 1", bus.page_idx, bus.page_tick); end
        tick();
        n_tests++; if (bus.page_idx !== 2'd2 || bus.page_tick !== 1'b0) begin n_fail++; $display("FAIL inval_settle: got page %0d tick %b expected page 2 tick 0", bus.page_idx, bus.page_tick); end
    endtask

    task automatic test_blank();
        do_reset();
        bus.page_valid = 3'b000;
        for (int n = 1; n <= 10; n++) begin
            tick();
            n_tests++; if (bus.anode !== 4'b1111 || bus.seg !== 8'hFF) begin n_fail++; $display("FAIL novalid_dark n=%0d: got anode %b seg %h expected 1111 ff", n, bus.anode, bus.seg); end
        end
        bus.page_valid = 3'b111;
        bus.blank_all  = 1'b1;
        for (int n = 11; n <= 14; n++) begin
            tick();
            n_tests++; if (bus.anode !== 4'b1111 || bus.seg !== 8'hFF) begin n_fail++; $display("FAIL blank_dark n=%0d: got anode %b seg %h expected 1111 ff", n, bus.anode, bus.seg); end
        end
        bus.blank_all = 1'b0;
        tick();
        n_tests++; if (bus.anode !== 4'b0111 || bus.seg !== 8'h99) begin n_fail++; $display("FAIL blank_release: got anode %b seg %h expected 0111 99", bus.anode, bus.seg); end
        n_tests++; if (bus.page_idx !== 2'd0) begin n_fail++; $display("FAIL blank_page_hold: got %0d expected 0", bus.page_idx); end
    endtask

    task automatic test_char_codes();
        do_reset();
        chars[0][1] = 5'd31;
        chars[0][2] = 5'd10;
        load_chars();
        bus.page_dp[3] = 1'b1;
        for (int n = 1; n <= 13; n++) begin
            tick();
            if (n == 1) begin
                n_tests++; if (bus.anode !== 4'b1110 || bus.seg !== 8'hF9) begin n_fail++; $display("FAIL code_digit: got anode %b seg %h expected 1110 f9", bus.anode, bus.seg); end
            end
            if (n == 5) begin
                n_tests++; if (bus.anode !== 4'b1101 || bus.seg !== 8'hFF) begin n_fail++; $display("FAIL code_blank31: got anode %b seg %h expected 1101 ff", bus.anode, bus.seg); end
            end
            if (n == 9) begin
                n_tests++; if (bus.anode !== 4'b1011 || bus.seg !== 8'h88) begin n_fail++; $display("FAIL code_letterA: got anode %b seg %h expected 1011 88", bus.anode, bus.seg); end
            end
            if (n == 13) begin
                n_tests++; if (bus.anode !== 4'b0111 || bus.seg !== 8'h19) begin n_fail++; $display("FAIL code_dp: got anode %b seg %h expected 0111 19", bus.anode, bus.seg); end
            end
        end
        init_chars();
        load_chars();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int n = 1; n <= 142; n++) tick();
        n_tests++; if (bus.page_idx !== 2'd2 || bus.anode !== 4'b0111) begin n_fail++; $display("FAIL mid_setup: got page %0d anode %b expected page 2 anode 0111", bus.page_idx, bus.anode); end
        reset = 1'b1;
        tick();
        n_tests++; if (bus.page_idx !== 2'd0 || bus.anode !== 4'b1111 || bus.seg !== 8'hFF || bus.page_tick !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got page %0d anode %b seg %h tick %b expected 0 1111 ff 0", bus.page_idx, bus.anode, bus.seg, bus.page_tick); end
        reset = 1'b0;
        tick();
        n_tests++; if (bus.page_idx !== 2'd0 || bus.anode !== 4'b1110 || bus.seg !== 8'hF9) begin n_fail++; $display("FAIL mid_restart: got page %0d anode %b seg %h expected 0 1110 f9", bus.page_idx, bus.anode, bus.seg); end
    endtask

    initial begin
        test_reset();
        test_auto_rotate();
        test_skip_invalid();
        test_manual_step();
        test_step_dwell_collision();
        test_invalidate_current();
        test_blank();
        test_char_codes();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_page_scanner.md
# seg_page_scanner

Parametrised multi-page driver for a common-anode 7-segment display. It time-multiplexes NUM_DIGITS digits and rotates through up to NUM_PAGES messages (for example password and encrypted output), either automatically on a dwell timer or manually on a step pulse. It sits between the cipher/datapath blocks, which supply character codes, and the board's anode/cathode pins, replacing the fixed 4-digit, 2-message display top.

## Interface
Parameters:
- NUM_DIGITS, 4: digits on the display; must be 2..8.
- NUM_PAGES, 2: message pages; must be 1..8.
- CHAR_W, 5: character code width.
- REFRESH_DIV, 100_000: clk cycles per digit slot.
- DWELL_DIV, 200_000_000: clk cycles per page in auto mode.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- mode  in  1  0 = auto rotate, 1 = manual.
- step  in  1  single-cycle pulse that advances the page; already debounced.
- blank_all  in  1  forces the display dark.
- page_valid  in  NUM_PAGES  bit p = 1 means page p is eligible for display.
- page_chars  in  NUM_PAGES*NUM_DIGITS*CHAR_W  character of page p, digit d is at offset (p*NUM_DIGITS+d)*CHAR_W.
- page_dp  in  NUM_PAGES*NUM_DIGITS  decimal point per digit, 1 = lit.
- anode  out  NUM_DIGITS  active-low digit enables.
- seg  out  8  active-low segments; bits [6:0] = g..a, bit 7 = dp.
- page_idx  out  max(1,$clog2(NUM_PAGES))  page currently shown.
- page_tick  out  1  one-cycle pulse on every page change.

## Operation
- Refresh counter counts 0..REFRESH_DIV-1, then wraps. On wrap, digit_idx advances modulo NUM_DIGITS. Digit 0 is rightmost.
- Page advance target: the next page with a set valid bit, searching from page_idx+1 upward and wrapping. If page_idx is the only valid page, the page does not change and page_tick does not fire.
- Auto mode: dwell counter counts 0..DWELL_DIV-1. On wrap, the page advances.
- step advances the page in either mode.
- If the dwell wrap and step fall in the same cycle, the page advances exactly once.
- Dwell counter clears on every page change and on a mode change.
- If the current page becomes invalid and another page is valid, the page moves to the next valid page on the following cycle and page_tick fires. This takes priority over dwell and step.
- If no page is valid, or blank_all = 1:
  - anode is all ones and seg = 8'hFF.
  - The counters keep running.
  - page_idx holds.
- Character decode follows the team character table:
  - 0..9 are digits.
  - 10..30 are letters.
  - 31 is blank (segments off).
  - Any code not in the table decodes as blank.
- Reset values:
  - anode all ones.
  - seg = 8'hFF.
  - page_idx = 0.
  - page_tick = 0.
  - Both counters = 0.
  - digit_idx = 0.
- Reset mid-operation returns to these values on the next edge, regardless of mode.

## Timing
- anode and seg are registered and update one cycle after digit_idx or page_idx changes. They never show a mixed digit/page combination.
- page_tick is high during the cycle in which the new page_idx first appears.
- Auto mode, all pages valid: a page change occurs exactly every DWELL_DIV cycles.
- A step on cycle n gives a new page_idx on cycle n+1.
- blank_all takes effect on outputs one cycle after it is asserted.
- Inputs are sampled every cycle; page_chars is not latched.

## Structure
- Package seg_pkg holds:
  - the character-to-segment table as a function,
  - the BLANK_CODE = 31 constant,
  - the segment bit-order constants.
- Sub-module seg_char_decode: combinational, converts CHAR_W code plus dp into 8-bit active-low seg. Instantiate once, after the digit mux.
- The remaining logic lives in seg_page_scanner:
  - refresh counter,
  - dwell counter,
  - next-valid-page search,
  - output registers.

## Test plan
Use NUM_DIGITS=4, NUM_PAGES=3, REFRESH_DIV=4, DWELL_DIV=64, page_chars set to digits 1-2-3-4 / 5-6-7-8 / 9-0-1-2.

- Reset then run in auto mode, all pages valid:
  - anode cycles 1110, 1101, 1011, 0111, changing every 4 cycles.
  - seg matches the decode of page 0's digits.
  - page_idx goes 0→1→2→0, one change every 64 cycles, with a page_tick on each change.
- page_valid = 3'b101 in auto mode: page_idx alternates 0,2,0; page 1 is never shown.
- Manual mode, step pulses at cycles 10 and 11:
  - page_idx is 1 at cycle 11 and 2 at cycle 12.
  - No advance happens without a step, even after 200 cycles.
- Auto mode, step in the same cycle as a dwell wrap: page_idx advances by 1 only, and page_tick is high for 1 cycle only.
- Clear page_valid[1] while page 1 is shown: the page moves to page 2 on the next cycle with page_tick.
- page_valid = 0, then blank_all: anode = 1111 and seg = 8'hFF. With valid pages and code 31: the digit's segments are dark while its anode is still active.
- Assert reset mid-rotation at page 2, digit 3: the next cycle shows page_idx = 0, anode = 1111, seg = FF.
